alu_exec_ctrl: RTL and testbench
================================

Name: alu_exec_ctrl

Overview:
Multi-cycle execute sequencer for the RISC-V integer ALU (R-type ADD/SUB/MUL/AND/OR/XOR/SLT/SLTU/SLL/SRL/SRA and I-type equivalents).
- Accepts one 32-bit instruction per valid/ready handshake and checks it is a legal ALU instruction.
- Reads rs1/rs2 from the register file, drives the external combinational ALU for a configured number of settle cycles, then writes rd back.
- Sits between the decode/issue stage and the shared ALU plus register file write port.

Parameters:
ALU_CYCLES, 1, EX cycles held for non-MUL ops (min 1)
MUL_CYCLES, 4, EX cycles held for MUL (min 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  issue stage presents instruction
instr_ready  out  1  controller can accept instruction
instr  in  32  instruction word
rf_raddr1  out  5  register file read address (rs1)
rf_raddr2  out  5  register file read address (rs2)
rf_rdata1  in  32  combinational read data for rf_raddr1
rf_rdata2  in  32  combinational read data for rf_raddr2
alu_code  out  32  instruction word driven to ALU
alu_rs1  out  32  ALU operand 1
alu_rs2  out  32  ALU operand 2 (0 for I-type)
alu_rd  in  32  ALU result
rf_we  out  1  register file write enable
rf_waddr  out  5  write address
rf_wdata  out  32  write data
done  out  1  one-cycle retire pulse
illegal  out  1  one-cycle illegal-instruction pulse
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; all registers cleared; every output 0, including instr_ready.
- Reset mid-operation aborts the in-flight instruction with no write.
- FSM states: IDLE, RD, EX, WB, ERR.
- IDLE:
  - instr_ready=1 (combinational, state==IDLE && !rst).
  - On instr_valid&&instr_ready, latch instr into ir.
  - Legal instruction: go to RD. Illegal instruction: go to ERR.
- RD (1 cycle):
  - rf_raddr1=ir[19:15], rf_raddr2=ir[24:20].
  - At end of cycle, capture opa=rf_rdata1 and opb=(R-type ? rf_rdata2 : 0).
  - Load cnt = (MUL ? MUL_CYCLES : ALU_CYCLES) - 1. Go to EX.
- EX:
  - alu_code=ir, alu_rs1=opa, alu_rs2=opb, all held stable.
  - cnt decrements each cycle. When cnt==0, capture res=alu_rd and go to WB.
  - alu_* outputs are 0 in every state other than EX.
- WB (1 cycle):
  - done=1, rf_waddr=ir[11:7], rf_wdata=res.
  - rf_we=1 only if ir[11:7]!=0; rd=x0 retires with no write.
  - Go to IDLE.
- ERR (1 cycle): illegal=1, done=1, rf_we=0. Go to IDLE.
- Latency (handshake at edge k):
  - RD in cycle k+1; EX in cycles k+2..k+1+N; WB in cycle k+2+N.
  - instr_ready returns in cycle k+3+N. Throughput: 1 instruction per N+3 cycles.
  - Illegal instruction: ERR in cycle k+1, ready again in k+2.
- Legality:
  - opcode 0110011 (R-type):
    - funct7=0000000: any funct3 is legal.
    - funct7=0100000: legal only with funct3 000 or 101.
    - funct7=0000001: legal only with funct3 000 (MUL).
  - opcode 0010011 (I-type):
    - funct3 001 requires ir[31:25]=0000000.
    - funct3 101 requires ir[31:25] in {0000000, 0100000}.
    - Other funct3 values: any immediate is legal.
  - All other opcodes are illegal.
- instr_valid is ignored outside IDLE. The instr port is not sampled after the handshake.
- Arithmetic is done by the ALU only; the controller performs no arithmetic besides cnt.

Decomposition:
- Shared package riscv_pkg:
  - OPC_RTYPE=7'b0110011, OPC_ITYPE=7'b0010011.
  - F7_BASE=0000000, F7_ALT=0100000, F7_MULDIV=0000001.
  - funct3 codes.
  - State enum {IDLE, RD, EX, WB, ERR}.
- One sub-module, alu_instr_chk: combinational. Input instr[31:0]; outputs legal, is_rtype, is_mul.
- The ALU itself is instantiated outside and connected through the alu_* ports.

Test Plan:
- ADD x3,x2,x4 (instr=0x004101B3), rf x2=2, x4=4, alu_rd modelled:
  - rf_raddr1=2 and rf_raddr2=4 in cycle k+1; alu_rs1=2, alu_rs2=4 in k+2.
  - WB in k+3 with rf_we=1, rf_waddr=3, rf_wdata=6, done=1; instr_ready=1 in k+4.
- MUL x5,x2,x4 (0x024102B3), MUL_CYCLES=4: EX holds for 4 cycles (k+2..k+5), WB in k+6 with rf_wdata=8 and rf_waddr=5.
- ADDI x1,x7,3 (0x00338093), x7=7: alu_rs2=0 during EX; rf_wdata=10, rf_waddr=1.
- Illegal SUB-form with funct3=111 (0x404171B3), and opcode 0000011:
  - illegal=1 and done=1 in k+1; rf_we never asserted.
  - instr_ready=1 in k+2.
- ADD with rd=x0 (0x00410033): done=1 in WB with rf_we=0.
- Back-to-back operation and reset:
  - instr_valid held high: instructions are accepted only every N+3 cycles.
  - rst asserted during EX: all outputs are 0 immediately with no write; after release, instr_ready=1 in the first cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V ALU encodings and execute-sequencer state type.
package riscv_pkg;

   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE = 7'b0010011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      EX   = 3'd2,
      WB   = 3'd3,
      ERR  = 3'd4
   } exec_state_e;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Issue, register-file and ALU signals of the execute sequencer.
interface alu_exec_ctrl_if;

   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic [31:0] alu_code;
   logic [31:0] alu_rs1;
   logic [31:0] alu_rs2;
   logic [31:0] alu_rd;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        done;
   logic        illegal;
   logic        busy;

   modport master (
      output instr_valid, instr, rf_rdata1, rf_rdata2, alu_rd,
      input  instr_ready, rf_raddr1, rf_raddr2, alu_code, alu_rs1, alu_rs2,
             rf_we, rf_waddr, rf_wdata, done, illegal, busy
   );

   modport slave (
      input  instr_valid, instr, rf_rdata1, rf_rdata2, alu_rd,
      output instr_ready, rf_raddr1, rf_raddr2, alu_code, alu_rs1, alu_rs2,
             rf_we, rf_waddr, rf_wdata, done, illegal, busy
   );

endinterface

// File: rtl/alu_instr_chk.sv
// Combinational legality decode for RV32I/M integer ALU instructions.
module alu_instr_chk
   import riscv_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic        legal_o,
   output logic        is_rtype_o,
   output logic        is_mul_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   // Only shifts constrain the upper immediate bits of I-type ops.
   always_comb begin
      legal_o    = 1'b0;
      is_rtype_o = 1'b0;
      is_mul_o   = 1'b0;
      if (opcode == OPC_RTYPE) begin
         is_rtype_o = 1'b1;
         is_mul_o   = (funct7 == F7_MULDIV) && (funct3 == F3_ADD);
         legal_o    = (funct7 == F7_BASE)
                   || ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)))
                   || is_mul_o;
      end else if (opcode == OPC_ITYPE) begin
         case (funct3)
            F3_SLL:  legal_o = (funct7 == F7_BASE);
            F3_SR:   legal_o = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            default: legal_o = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute sequencer: read operands, hold the external ALU, write back.
module alu_exec_ctrl
   import riscv_pkg::*;
#(
   parameter int ALU_CYCLES = 1,
   parameter int MUL_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   alu_exec_ctrl_if.slave   bus
);

   localparam int MAX_CYC = (MUL_CYCLES > ALU_CYCLES) ? MUL_CYCLES : ALU_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   exec_state_e      state_q;
   logic [31:0]      ir_q;
   logic             rtype_q;
   logic             mul_q;
   logic [CNT_W-1:0] cnt_q;
   logic [4:0]       raddr1_q;
   logic [4:0]       raddr2_q;
   logic [31:0]      aluCode_q;
   logic [31:0]      aluRs1_q;
   logic [31:0]      aluRs2_q;
   logic             rfWe_q;
   logic [4:0]       rfWaddr_q;
   logic [31:0]      rfWdata_q;
   logic             done_q;
   logic             illegal_q;

   logic chkLegal;
   logic chkRtype;
   logic chkMul;

   alu_instr_chk u_chk (
      .instr_i    (bus.instr),
      .legal_o    (chkLegal),
      .is_rtype_o (chkRtype),
      .is_mul_o   (chkMul)
   );

   // Each output register is set on entry to the state that owns it and cleared on exit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ir_q      <= '0;
         rtype_q   <= 1'b0;
         mul_q     <= 1'b0;
         cnt_q     <= '0;
         raddr1_q  <= '0;
         raddr2_q  <= '0;
         aluCode_q <= '0;
         aluRs1_q  <= '0;
         aluRs2_q  <= '0;
         rfWe_q    <= 1'b0;
         rfWaddr_q <= '0;
         rfWdata_q <= '0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.instr_valid) begin
                  ir_q    <= bus.instr;
                  rtype_q <= chkRtype;
                  mul_q   <= chkMul;
                  if (chkLegal) begin
                     raddr1_q <= bus.instr[19:15];
                     raddr2_q <= bus.instr[24:20];
                     state_q  <= RD;
                  end else begin
                     illegal_q <= 1'b1;
                     done_q    <= 1'b1;
                     state_q   <= ERR;
                  end
               end
            end
            RD: begin
               raddr1_q  <= '0;
               raddr2_q  <= '0;
               aluCode_q <= ir_q;
               aluRs1_q  <= bus.rf_rdata1;
               aluRs2_q  <= rtype_q ? bus.rf_rdata2 : 32'd0;
               cnt_q     <= mul_q ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(ALU_CYCLES - 1);
               state_q   <= EX;
            end
            EX: begin
               if (cnt_q == '0) begin
                  aluCode_q <= '0;
                  aluRs1_q  <= '0;
                  aluRs2_q  <= '0;
                  rfWdata_q <= bus.alu_rd;
                  rfWaddr_q <= ir_q[11:7];
                  rfWe_q    <= (ir_q[11:7] != 5'd0);
                  done_q    <= 1'b1;
                  state_q   <= WB;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            WB: begin
               rfWe_q    <= 1'b0;
               rfWaddr_q <= '0;
               rfWdata_q <= '0;
               done_q    <= 1'b0;
               state_q   <= IDLE;
            end
            ERR: begin
               illegal_q <= 1'b0;
               done_q    <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.instr_ready = (state_q == IDLE) && !rst;
   assign bus.busy        = (state_q != IDLE);
   assign bus.rf_raddr1   = raddr1_q;
   assign bus.rf_raddr2   = raddr2_q;
   assign bus.alu_code    = aluCode_q;
   assign bus.alu_rs1     = aluRs1_q;
   assign bus.alu_rs2     = aluRs2_q;
   assign bus.rf_we       = rfWe_q;
   assign bus.rf_waddr    = rfWaddr_q;
   assign bus.rf_wdata    = rfWdata_q;
   assign bus.done        = done_q;
   assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a toy register file and ALU model.
module tb_alu_exec_ctrl;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   weCount;

   alu_exec_ctrl_if bus ();

   alu_exec_ctrl #(.ALU_CYCLES(1), .MUL_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register xi holds the value i.
   assign bus.rf_rdata1 = {27'd0, bus.rf_raddr1};
   assign bus.rf_rdata2 = {27'd0, bus.rf_raddr2};

   // ALU model covering the ops exercised here: ADD, SUB, MUL, ADDI.
   always_comb begin
      bus.alu_rd = 32'd0;
      if (bus.alu_code[6:0] == 7'b0110011) begin
         if (bus.alu_code[31:25] == 7'b0000001)      bus.alu_rd = bus.alu_rs1 * bus.alu_rs2;
         else if (bus.alu_code[31:25] == 7'b0100000) bus.alu_rd = bus.alu_rs1 - bus.alu_rs2;
         else                                        bus.alu_rd = bus.alu_rs1 + bus.alu_rs2;
      end else if (bus.alu_code[6:0] == 7'b0010011) begin
         bus.alu_rd = bus.alu_rs1 + {{20{bus.alu_code[31]}}, bus.alu_code[31:20]};
      end
   end

   always @(negedge clk) if (bus.rf_we === 1'b1) weCount++;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic issue(input logic [31:0] word);
      @(negedge clk);
      bus.instr       = word;
      bus.instr_valid = 1'b1;
      total++;
      if (bus.instr_ready !== 1'b1) begin
         bad++; $display("[TB] FAIL issue_ready got=%b want=1 instr=%h", bus.instr_ready, word);
      end
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
      bus.instr       = 32'hDEAD_BEEF;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr = 32'd0;
      repeat (2) @(negedge clk);
      total++;
      if ({bus.instr_ready, bus.busy, bus.done, bus.rf_we, bus.illegal} !== 5'b0) begin
         bad++; $display("[TB] FAIL reset_outs got=%b want=00000",
                         {bus.instr_ready, bus.busy, bus.done, bus.rf_we, bus.illegal});
      end
      total++;
      if (bus.alu_code !== 32'd0) begin
         bad++; $display("[TB] FAIL reset_alu_code got=%h want=0", bus.alu_code);
      end
      rst = 1'b0;
      #1;
      total++;
      if (bus.instr_ready !== 1'b1) begin
         bad++; $display("[TB] FAIL reset_ready got=%b want=1", bus.instr_ready);
      end
   endtask

   task automatic test_add();
      issue(32'h004101B3);
      @(negedge clk);
      total++;
      if (bus.rf_raddr1 !== 5'd2 || bus.rf_raddr2 !== 5'd4) begin
         bad++; $display("[TB] FAIL add_raddr got=%0d,%0d want=2,4", bus.rf_raddr1, bus.rf_raddr2);
      end
      @(negedge clk);
      total++;
      if (bus.alu_rs1 !== 32'd2 || bus.alu_rs2 !== 32'd4 || bus.alu_code !== 32'h004101B3) begin
         bad++; $display("[TB] FAIL add_ex got=%h,%h,%h want=2,4,004101b3", bus.alu_rs1, bus.alu_rs2, bus.alu_code);
      end
      @(negedge clk);
      total++;
      if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'd6 || bus.done !== 1'b1) begin
         bad++; $display("[TB] FAIL add_wb got=we%b a%0d d%0d done%b want=we1 a3 d6 done1",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done);
      end
      total++;
      if (bus.alu_rs1 !== 32'd0) begin
         bad++; $display("[TB] FAIL add_alu_cleared got=%h want=0", bus.alu_rs1);
      end
      @(negedge clk);
      total++;
      if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0) begin
         bad++; $display("[TB] FAIL add_ready got=%b,%b want=1,0", bus.instr_ready, bus.done);
      end
   endtask

   task automatic test_mul();
      issue(32'h024102B3);
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if (bus.alu_rs1 !== 32'd2 || bus.alu_rs2 !== 32'd4 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            bad++; $display("[TB] FAIL mul_ex%0d got=%h,%h,done%b want=2,4,done0", c, bus.alu_rs1, bus.alu_rs2, bus.done);
         end
      end
      @(negedge clk);
      total++;
      if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'd8 || bus.done !== 1'b1) begin
         bad++; $display("[TB] FAIL mul_wb got=we%b a%0d d%0d done%b want=we1 a5 d8 done1",
                         bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.done);
      end
      @(negedge clk);
   endtask

   task automatic test_addi();
      issue(32'h00338093);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bus.alu_rs1 !== 32'd7 || bus.alu_rs2 !== 32'd0) begin
         bad++; $display("[TB] FAIL addi_ex got=%h,%h want=7,0", bus.alu_rs1, bus.alu_rs2);
      end
      @(negedge clk);
      total++;
      if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd1 || bus.rf_wdata !== 32'd10) begin
         bad++; $display("[TB] FAIL addi_wb got=we%b a%0d d%0d want=we1 a1 d10", bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      end
      @(negedge clk);
   endtask

   task automatic test_illegal(input logic [31:0] word);
      int weBefore;
      weBefore = weCount;
      issue(word);
      @(negedge clk);
      total++;
      if (bus.illegal !== 1'b1 || bus.done !== 1'b1 || bus.rf_we !== 1'b0 || bus.busy !== 1'b1) begin
         bad++; $display("[TB] FAIL illegal_pulse %h got=ill%b done%b we%b want=ill1 done1 we0",
                         word, bus.illegal, bus.done, bus.rf_we);
      end
      @(negedge clk);
      total++;
      if (bus.instr_ready !== 1'b1 || bus.illegal !== 1'b0 || bus.done !== 1'b0) begin
         bad++; $display("[TB] FAIL illegal_ready %h got=rdy%b ill%b want=rdy1 ill0", word, bus.instr_ready, bus.illegal);
      end
      total++;
      if (weCount !== weBefore) begin
         bad++; $display("[TB] FAIL illegal_nowrite got=%0d want=%0d", weCount, weBefore);
      end
   endtask

   task automatic test_rd_x0();
      int weBefore;
      weBefore = weCount;
      issue(32'h00410033);
      repeat (3) @(negedge clk);
      total++;
      if (bus.done !== 1'b1 || bus.rf_we !== 1'b0) begin
         bad++; $display("[TB] FAIL x0_wb got=done%b we%b want=done1 we0", bus.done, bus.rf_we);
      end
      @(negedge clk);
      total++;
      if (weCount !== weBefore || bus.instr_ready !== 1'b1) begin
         bad++; $display("[TB] FAIL x0_nowrite got=%0d rdy%b want=%0d rdy1", weCount, bus.instr_ready, weBefore);
      end
   endtask

   task automatic test_back_to_back();
      int acc[4];
      int n;
      n = 0;
      @(negedge clk);
      bus.instr       = 32'h004101B3;
      bus.instr_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (bus.instr_ready === 1'b1 && n < 4) begin
            acc[n] = i;
            n++;
         end
         @(negedge clk);
      end
      bus.instr_valid = 1'b0;
      total++;
      if (n !== 3) begin
         bad++; $display("[TB] FAIL b2b_count got=%0d want=3", n);
      end else begin
         total++;
         if (acc[0] !== 0 || acc[1] !== 4 || acc[2] !== 8) begin
            bad++; $display("[TB] FAIL b2b_spacing got=%0d,%0d,%0d want=0,4,8", acc[0], acc[1], acc[2]);
         end
      end
      total++;
      if (bus.instr_ready !== 1'b1) begin
         bad++; $display("[TB] FAIL b2b_final_ready got=%b want=1", bus.instr_ready);
      end
   endtask

   task automatic test_reset_mid_ex();
      int weBefore;
      int waited;
      issue(32'h024102B3);
      repeat (3) @(negedge clk);
      total++;
      if (bus.alu_rs1 !== 32'd2) begin
         bad++; $display("[TB] FAIL rstex_in_ex got=%h want=2", bus.alu_rs1);
      end
      weBefore = weCount;
      rst = 1'b1;
      #1;
      total++;
      if ({bus.instr_ready, bus.busy, bus.done, bus.rf_we, bus.illegal} !== 5'b0 ||
          bus.alu_rs1 !== 32'd0 || bus.alu_code !== 32'd0 || bus.rf_wdata !== 32'd0) begin
         bad++; $display("[TB] FAIL rstex_outs got=%b rs1=%h code=%h want=all zero",
                         {bus.instr_ready, bus.busy, bus.done, bus.rf_we, bus.illegal}, bus.alu_rs1, bus.alu_code);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      total++;
      if (bus.instr_ready !== 1'b1 || bus.busy !== 1'b0) begin
         bad++; $display("[TB] FAIL rstex_ready got=rdy%b busy%b want=rdy1 busy0", bus.instr_ready, bus.busy);
      end
      waited = 0;
      while (waited < 8) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (weCount !== weBefore) begin
         bad++; $display("[TB] FAIL rstex_nowrite got=%0d want=%0d", weCount, weBefore);
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      weCount = 0;
      test_reset();
      test_add();
      test_mul();
      test_addi();
      test_illegal(32'h404171B3);
      test_illegal(32'h00412183);
      test_rd_x0();
      test_back_to_back();
      test_reset_mid_ex();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
